// File: rtl/delta_pkg.sv
// Shared definitions for the delta-modulation encoder/decoder pair:
// state encoding, sample width, default step and the saturating step update.
package delta_pkg;

    localparam int SAMPLE_W = 8;
    localparam logic [SAMPLE_W-1:0] DEFAULT_STEP = 8'd8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // One extra bit of headroom holds approx +/- step (step <= 127) without wrap.
    function automatic sample_t sat_step(input sample_t a, input logic up,
                                         input logic [SAMPLE_W-1:0] step);
        logic signed [SAMPLE_W:0] w_a;
        logic signed [SAMPLE_W:0] w_d;
        logic signed [SAMPLE_W:0] w_s;
        w_a = {a[SAMPLE_W-1], a};
        w_d = $signed({1'b0, step});
        w_s = up ? (w_a + w_d) : (w_a - w_d);
        if (w_s > 9'sh07F) begin
            return 8'sh7F;
        end else if (w_s < 9'sh180) begin
            return 8'sh80;
        end
        return w_s[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/delta_encode_if.sv
// Sample-in / code-out bus of the delta encoder, plus the FSM state for observation.
interface delta_encode_if;
    import delta_pkg::*;

    // Both channels use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both 1; the source holds data stable while valid is 1
    // and not yet taken, and valid never waits on ready.
    sample_t             sample;
    logic                sample_valid;
    logic                sample_ready;
    logic [0:SAMPLE_W-1] encode;
    logic                code_valid;
    logic                code_ready;
    sample_t             approx;
    state_t              state;

    modport master (
        output sample, sample_valid, code_ready,
        input  sample_ready, encode, code_valid, approx, state
    );

    modport slave (
        input  sample, sample_valid, code_ready,
        output sample_ready, encode, code_valid, approx, state
    );

endinterface

// File: rtl/delta_step.sv
// Combinational core of one delta step: compare the sample against the running
// approximation and produce the code bit and the saturated next approximation.
module delta_step
    import delta_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] STEP = DEFAULT_STEP
) (
    input  sample_t i_sample,
    input  sample_t i_approx,
    output logic    o_bit,
    output sample_t o_approx_next
);

    // Equality steps down, so a flat input settles into an up/down toggle.
    assign o_bit         = (i_sample > i_approx);
    assign o_approx_next = sat_step(i_approx, o_bit, STEP);

endmodule

// File: rtl/delta_encode.sv
// Delta-modulation encoder: one bit per accepted sample, packed eight at a time
// into encode[0:7] (oldest bit at index 0) and held until the consumer takes it.
module delta_encode
    import delta_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] STEP = DEFAULT_STEP
) (
    input logic           CLK100MHZ,
    input logic           reset_n,
    input logic           start,
    delta_encode_if.slave enc
);

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_count;
    logic [0:SAMPLE_W-1] r_shift;
    logic [0:SAMPLE_W-1] r_encode;
    sample_t             r_approx;

    logic                w_sample_ready;
    logic                w_accept;
    logic                w_last;
    logic                w_bit;
    sample_t             w_approx_next;
    logic [0:SAMPLE_W-1] w_byte;

    delta_step #(
        .STEP (STEP)
    ) u_step (
        .i_sample      (enc.sample),
        .i_approx      (r_approx),
        .o_bit         (w_bit),
        .o_approx_next (w_approx_next)
    );

    // Ready is gated by start so a sample offered during the abort cycle is not taken.
    assign w_sample_ready = (r_state == ST_COLLECT) && start;
    assign w_accept       = enc.sample_valid && w_sample_ready;
    assign w_last         = (r_count == 3'd7);

    always_comb begin
        w_byte          = r_shift;
        w_byte[r_count] = w_bit;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_next = ST_COLLECT;
            ST_COLLECT: if (w_accept && w_last) w_state_next = ST_HOLD;
            ST_HOLD:    if (enc.code_ready) w_state_next = ST_COLLECT;
            default:    w_state_next = ST_IDLE;
        endcase
        if (!start) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= 3'd0;
            r_shift  <= '0;
            r_encode <= '0;
            r_approx <= '0;
        end else if (!start || (r_state == ST_IDLE)) begin
            r_count  <= 3'd0;
            r_shift  <= '0;
            r_approx <= '0;
        end else if (w_accept) begin
            r_approx <= w_approx_next;
            r_count  <= r_count + 3'd1;
            if (w_last) begin
                r_encode <= w_byte;
                r_shift  <= '0;
            end else begin
                r_shift  <= w_byte;
            end
        end
    end

    assign enc.sample_ready = w_sample_ready;
    assign enc.code_valid   = (r_state == ST_HOLD);
    assign enc.encode       = r_encode;
    assign enc.approx       = r_approx;
    assign enc.state        = r_state;

endmodule

// File: tb/tb_delta_encode.sv
// Directed bench for delta_encode: a reference model pushes expected bytes and
// end-of-byte approximations; bytes taken from the DUT are popped, compared and
// decoded back to check that the code stream rebuilds the approximation.
module tb_delta_encode;
    import delta_pkg::*;

    localparam int STEP_TB = 8;

    typedef struct {
        logic [0:7] code;
        logic       fresh;
        int         approx_end;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;

    delta_encode_if enc ();

    delta_encode #(
        .STEP (8'd8)
    ) dut (
        .CLK100MHZ (clk),
        .reset_n   (rst_n),
        .start     (start),
        .enc       (enc)
    );

    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    exp_t       exp_q[$];
    int         m_approx = 0;
    logic [0:7] m_bits   = '0;
    int         m_cnt    = 0;
    logic       m_fresh  = 1'b1;
    int         dec_acc  = 0;
    logic [7:0] got;

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_approx = 0;
        m_cnt    = 0;
        m_bits   = '0;
        m_fresh  = 1'b1;
    endtask

    // Entered and left on a falling edge.
    task automatic send(input int s);
        int   waited;
        logic b;
        waited = 0;
        enc.sample       = s[7:0];
        enc.sample_valid = 1'b1;
        #1;
        while (enc.sample_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("send_ready", enc.sample_ready, 1);
        b = (s > m_approx);
        m_approx = sat8(b ? m_approx + STEP_TB : m_approx - STEP_TB);
        m_bits[m_cnt] = b;
        m_cnt++;
        if (m_cnt == 8) begin
            exp_q.push_back('{code: m_bits, fresh: m_fresh, approx_end: m_approx});
            m_fresh = 1'b0;
            m_cnt   = 0;
        end
        @(posedge clk);
        #1;
        chk("approx", enc.approx, m_approx);
        enc.sample_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic take_byte(input int hold, output logic [7:0] code);
        int         waited;
        logic [0:7] snap;
        exp_t       e;
        waited = 0;
        while (enc.code_valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("code_valid_rise", enc.code_valid, 1);
        chk("code_valid_latency", waited, 0);
        snap = enc.encode;
        for (int i = 0; i < hold; i++) begin
            chk("bp_ready_low", enc.sample_ready, 0);
            chk("bp_valid_high", enc.code_valid, 1);
            chk("bp_encode_stable", enc.encode, snap);
            @(negedge clk);
            #1;
        end
        chk("hold_ready_low", enc.sample_ready, 0);
        code = enc.encode;
        chk("queue_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("byte", enc.encode, e.code);
            if (e.fresh) dec_acc = 0;
            for (int i = 0; i < 8; i++) begin
                dec_acc = sat8(code[7-i] ? dec_acc + STEP_TB : dec_acc - STEP_TB);
            end
            chk("loopback", dec_acc, e.approx_end);
        end
        enc.code_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("resume_ready", enc.sample_ready, 1);
        chk("valid_dropped", enc.code_valid, 0);
        enc.code_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic restart();
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("stop_state", enc.state, ST_IDLE);
        chk("stop_approx", enc.approx, 0);
        chk("stop_valid", enc.code_valid, 0);
        chk("stop_ready", enc.sample_ready, 0);
        @(negedge clk);
        start = 1'b1;
        reset_model();
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        start            = 1'b0;
        enc.sample       = '0;
        enc.sample_valid = 1'b0;
        enc.code_ready   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sample_ready", enc.sample_ready, 0);
        chk("rst_code_valid", enc.code_valid, 0);
        chk("rst_encode", enc.encode, 8'h00);
        chk("rst_approx", enc.approx, 0);
        chk("rst_state", enc.state, ST_IDLE);

        rst_n = 1'b1;
        start = 1'b1;
        #1;
        chk("ready_before_edge", enc.sample_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_start", enc.sample_ready, 1);
        @(negedge clk);
        reset_model();

        // Constant +40 input.
        for (int i = 0; i < 8; i++) send(40);
        chk("t1_approx_end", enc.approx, 32);
        take_byte(0, got);
        chk("t1_byte0", got, 8'b11111010);
        for (int i = 0; i < 8; i++) send(40);
        take_byte(0, got);
        chk("t1_byte1", got, 8'b10101010);

        // Positive saturation.
        restart();
        for (int i = 0; i < 24; i++) begin
            send(127);
            if (i == 15) chk("t2_approx_127", enc.approx, 127);
            if ((i % 8) == 7) take_byte(0, got);
        end
        chk("t2_last_byte", got, 8'b01010101);

        // Negative saturation.
        restart();
        for (int i = 0; i < 24; i++) begin
            send(-128);
            if (i >= 15) chk("t3_approx_pinned", enc.approx, 32'hFFFF_FF80);
            if ((i % 8) == 7) take_byte(0, got);
        end
        chk("t3_last_byte", got, 8'h00);

        // Back-pressure with random samples.
        restart();
        for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 255)) - 128);
        take_byte(5, got);

        // Abort by dropping start after 3 samples.
        restart();
        for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 255)) - 128);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_state", enc.state, ST_IDLE);
        chk("abort_approx", enc.approx, 0);
        chk("abort_valid", enc.code_valid, 0);
        @(negedge clk);
        start = 1'b1;
        reset_model();
        @(negedge clk);
        for (int i = 0; i < 8; i++) send(40);
        take_byte(0, got);
        chk("abort_fresh_byte", got, 8'b11111010);

        // Abort by asynchronous reset pulse mid-byte.
        for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 255)) - 128);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_approx", enc.approx, 0);
        chk("arst_ready", enc.sample_ready, 0);
        chk("arst_state", enc.state, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        @(negedge clk);
        for (int i = 0; i < 8; i++) send(40);
        take_byte(0, got);
        chk("arst_fresh_byte", got, 8'b11111010);

        // Idle cycles with start high must hold approx and the bit count.
        restart();
        for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 255)) - 128);
        repeat (4) @(negedge clk);
        chk("idle_approx_hold", enc.approx, m_approx);
        chk("idle_state_hold", enc.state, ST_COLLECT);
        for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 255)) - 128);
        take_byte(0, got);

        // start falls in the same cycle the consumer takes the held byte.
        for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 255)) - 128);
        #1;
        chk("sim_valid", enc.code_valid, 1);
        chk("sim_queue_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("sim_byte", enc.encode, exp_q.pop_front().code);
        start          = 1'b0;
        enc.code_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("sim_state", enc.state, ST_IDLE);
        chk("sim_valid_drop", enc.code_valid, 0);
        chk("sim_approx", enc.approx, 0);
        enc.code_ready = 1'b0;
        @(negedge clk);

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
